// File: rtl/input_handshake_unit.sv
// input_handshake_unit
//   One-shot, handshaken capture of the switch bank for the core's input path.
//   A request (is_input) waits for a fresh press of the debounced confirmation
//   button, captures sw once, then holds the word valid until the request drops.
//   A button already held when the request arrives must be released first (ARM).
//
// Optional feature macro: INPUT_TIMEOUT_EN
//   Defined   : WAIT_PRESS forces a capture after TIMEOUT_CYCLES waiting cycles
//               and flags it on timed_out.
//   Undefined : the unit waits indefinitely; timed_out is tied to 0.
//
// Ports
//   slow_clock    in   processor clock, all state on rising edge
//   reset         in   synchronous active-high reset, highest priority
//   is_input      in   input request level, held until input_ready observed
//   confirmation  in   debounced button level
//   sw            in   [IO_WIDTH:0] switches; MSB=1 sign-extends, 0 zero-extends
//   IData         out  captured word
//   input_ready   out  captured word valid for current request
//   waiting       out  waiting for a user press (ARM or WAIT_PRESS)
//   wait_cycles   out  saturating cycles spent waiting in this request
//   capture_count out  wrapping count of captures since reset
//   timed_out     out  last capture was forced by timeout
module input_handshake_unit #(
   parameter int DATA_WIDTH          = 32,
   parameter int IO_WIDTH            = 16,
   parameter int WAIT_COUNT_WIDTH    = 16,
   parameter int CAPTURE_COUNT_WIDTH = 8,
   parameter int TIMEOUT_CYCLES      = 50000
) (
   input  logic                           slow_clock,
   input  logic                           reset,
   input  logic                           is_input,
   input  logic                           confirmation,
   input  logic [IO_WIDTH:0]              sw,
   output logic [DATA_WIDTH-1:0]          IData,
   output logic                           input_ready,
   output logic                           waiting,
   output logic [WAIT_COUNT_WIDTH-1:0]    wait_cycles,
   output logic [CAPTURE_COUNT_WIDTH-1:0] capture_count,
   output logic                           timed_out
);

`ifdef INPUT_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   localparam logic [WAIT_COUNT_WIDTH-1:0] TMO_LAST = WAIT_COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ARM, WAIT_PRESS, DONE} state_t;

   state_t state, state_d;
   logic   capture, tmo;

   logic [DATA_WIDTH-1:0]          data_d;
   logic [WAIT_COUNT_WIDTH-1:0]    wc_d;
   logic [CAPTURE_COUNT_WIDTH-1:0] cc_d;
   logic                           ready_d, waiting_d;
   logic                           sext;

   // sign bit replicated only when extension mode is selected
   assign sext = sw[IO_WIDTH] & sw[IO_WIDTH-1];

   // next-state
   always_comb begin
      state_d = state;
      capture = 1'b0;
      tmo     = 1'b0;
      unique case (state)
         IDLE: if (is_input) state_d = confirmation ? ARM : WAIT_PRESS;
         ARM: begin
            if (!is_input)         state_d = IDLE;
            else if (!confirmation) state_d = WAIT_PRESS;
         end
         WAIT_PRESS: begin
            // a real press on the timeout edge wins, so timed_out stays 0
            tmo = TMO_EN && !confirmation && (wait_cycles == TMO_LAST);
            if (!is_input) state_d = IDLE;  // dropped request beats a press
            else if (confirmation || tmo) begin
               capture = 1'b1;
               state_d = DONE;
            end
         end
         DONE: if (!is_input) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // next values of the registered outputs
   always_comb begin
      data_d    = IData;
      cc_d      = capture_count;
      wc_d      = wait_cycles;
      ready_d   = (state_d == DONE);
      waiting_d = (state_d == ARM) || (state_d == WAIT_PRESS);
      if (state == IDLE && state_d != IDLE)
         wc_d = '0;
      else if ((state == ARM || state == WAIT_PRESS) && wait_cycles != '1)
         wc_d = wait_cycles + 1'b1;
      if (capture) begin
         data_d = {{(DATA_WIDTH-IO_WIDTH){sext}}, sw[IO_WIDTH-1:0]};
         cc_d   = capture_count + 1'b1;
      end
   end

   // state and output registers
   always_ff @(posedge slow_clock) begin
      if (reset) begin
         state         <= IDLE;
         IData         <= '0;
         input_ready   <= 1'b0;
         waiting       <= 1'b0;
         wait_cycles   <= '0;
         capture_count <= '0;
      end else begin
         state         <= state_d;
         IData         <= data_d;
         input_ready   <= ready_d;
         waiting       <= waiting_d;
         wait_cycles   <= wc_d;
         capture_count <= cc_d;
      end
   end

`ifdef INPUT_TIMEOUT_EN
   always_ff @(posedge slow_clock) begin
      if (reset)                               timed_out <= 1'b0;
      else if (capture)                        timed_out <= tmo;
      else if (state == IDLE && state_d != IDLE) timed_out <= 1'b0;
   end
`else
   assign timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_input_handshake_unit.sv
module tb_input_handshake_unit;
   logic        slow_clock = 1'b0;
   logic        reset, is_input, confirmation;
   logic [16:0] sw;
   logic [31:0] IData;
   logic        input_ready, waiting, timed_out;
   logic [15:0] wait_cycles;
   logic [7:0]  capture_count;

   int n_chk  = 0;
   int n_fail = 0;

   input_handshake_unit #(
      .DATA_WIDTH(32), .IO_WIDTH(16), .WAIT_COUNT_WIDTH(16),
      .CAPTURE_COUNT_WIDTH(8), .TIMEOUT_CYCLES(8)
   ) dut (
      .slow_clock(slow_clock), .reset(reset), .is_input(is_input),
      .confirmation(confirmation), .sw(sw), .IData(IData),
      .input_ready(input_ready), .waiting(waiting), .wait_cycles(wait_cycles),
      .capture_count(capture_count), .timed_out(timed_out)
   );

   always #5 slow_clock = ~slow_clock;

   // advance one rising edge, then sample 1 time unit later
   task automatic step();
      @(posedge slow_clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; is_input = 1'b0; confirmation = 1'b0; sw = '0;
      #2;
      step(); step();
      reset = 1'b0;
      chk("rst_idata", IData, 32'h0);
      chk("rst_ready", {31'b0, input_ready}, 32'h0);
      chk("rst_waiting", {31'b0, waiting}, 32'h0);
      chk("rst_wc", {16'b0, wait_cycles}, 32'h0);
      chk("rst_cc", {24'b0, capture_count}, 32'h0);
      chk("rst_to", {31'b0, timed_out}, 32'h0);

      // basic request: enter WAIT_PRESS, three waiting edges, then press
      is_input = 1'b1;
      step();
      chk("t1_waiting", {31'b0, waiting}, 32'h1);
      chk("t1_wc0", {16'b0, wait_cycles}, 32'h0);
      step(); step(); step();
      chk("t1_wc3", {16'b0, wait_cycles}, 32'h3);
      chk("t1_noready", {31'b0, input_ready}, 32'h0);
      confirmation = 1'b1; sw = 17'h0_1234;
      step();
      chk("t1_ready", {31'b0, input_ready}, 32'h1);
      chk("t1_idata", IData, 32'h0000_1234);
      chk("t1_cc", {24'b0, capture_count}, 32'h1);
      chk("t1_wc4", {16'b0, wait_cycles}, 32'h4);
      chk("t1_waiting0", {31'b0, waiting}, 32'h0);
      confirmation = 1'b0; is_input = 1'b0;
      step();
      chk("t1_drop_ready", {31'b0, input_ready}, 32'h0);
      chk("t1_drop_idata", IData, 32'h0000_1234);
      chk("t1_drop_wc", {16'b0, wait_cycles}, 32'h4);

      // sign extension then zero extension of the same pattern
      sw = 17'h1_8001; is_input = 1'b1;
      step();
      confirmation = 1'b1;
      step();
      chk("t2_sext", IData, 32'hFFFF_8001);
      chk("t2_cc", {24'b0, capture_count}, 32'h2);
      confirmation = 1'b0; is_input = 1'b0;
      step();
      sw = 17'h0_8001; is_input = 1'b1;
      step();
      confirmation = 1'b1;
      step();
      chk("t2_zext", IData, 32'h0000_8001);
      chk("t2_cc3", {24'b0, capture_count}, 32'h3);
      confirmation = 1'b0; is_input = 1'b0;
      step();

      // button held before the request: ARM, no capture until release + press
      confirmation = 1'b1;
      step();
      is_input = 1'b1;
      step();
      chk("t3_arm_waiting", {31'b0, waiting}, 32'h1);
      chk("t3_arm_ready", {31'b0, input_ready}, 32'h0);
      step();
      chk("t3_arm_cc", {24'b0, capture_count}, 32'h3);
      chk("t3_arm_wc", {16'b0, wait_cycles}, 32'h1);
      confirmation = 1'b0;
      step();
      chk("t3_wp_ready", {31'b0, input_ready}, 32'h0);
      sw = 17'h0_00AA; confirmation = 1'b1;
      step();
      chk("t3_idata", IData, 32'h0000_00AA);
      chk("t3_cc", {24'b0, capture_count}, 32'h4);
      chk("t3_wc", {16'b0, wait_cycles}, 32'h3);

      // DONE ignores button toggles and switch changes
      confirmation = 1'b0; step();
      confirmation = 1'b1; step();
      confirmation = 1'b0; step();
      confirmation = 1'b1; step();
      sw = 17'h0_FFFF; step();
      chk("t4_idata_hold", IData, 32'h0000_00AA);
      chk("t4_cc_hold", {24'b0, capture_count}, 32'h4);
      chk("t4_ready_hold", {31'b0, input_ready}, 32'h1);
      confirmation = 1'b0; is_input = 1'b0;
      step();
      chk("t4_drop_ready", {31'b0, input_ready}, 32'h0);
      chk("t4_drop_idata", IData, 32'h0000_00AA);

      // reset in WAIT_PRESS coincident with a press
      is_input = 1'b1;
      step();
      chk("t5_wp", {31'b0, waiting}, 32'h1);
      confirmation = 1'b1; reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t5_ready", {31'b0, input_ready}, 32'h0);
      chk("t5_idata", IData, 32'h0);
      chk("t5_cc", {24'b0, capture_count}, 32'h0);
      chk("t5_waiting", {31'b0, waiting}, 32'h0);
      // press still held after reset: must arm, not capture
      step();
      chk("t5_arm_cc", {24'b0, capture_count}, 32'h0);
      chk("t5_arm_waiting", {31'b0, waiting}, 32'h1);
      is_input = 1'b0;
      step();
      chk("t5_idle_waiting", {31'b0, waiting}, 32'h0);
      // request drop beats a simultaneous press
      confirmation = 1'b0; is_input = 1'b1;
      step();
      is_input = 1'b0; confirmation = 1'b1;
      step();
      chk("t5_drop_cc", {24'b0, capture_count}, 32'h0);
      chk("t5_drop_ready", {31'b0, input_ready}, 32'h0);
      chk("t5_drop_waiting", {31'b0, waiting}, 32'h0);
      confirmation = 1'b0;
      step();

      // no press: timeout capture (feature) or indefinite wait (default)
      sw = 17'h0_0042; is_input = 1'b1;
      step();
      repeat (7) step();
      chk("t6_wc7", {16'b0, wait_cycles}, 32'h7);
      chk("t6_noready7", {31'b0, input_ready}, 32'h0);
      step();
`ifdef INPUT_TIMEOUT_EN
      chk("t6_to_ready", {31'b0, input_ready}, 32'h1);
      chk("t6_to_idata", IData, 32'h0000_0042);
      chk("t6_to_flag", {31'b0, timed_out}, 32'h1);
      chk("t6_to_cc", {24'b0, capture_count}, 32'h1);
`else
      repeat (3) step();
      chk("t6_wc11", {16'b0, wait_cycles}, 32'hB);
      chk("t6_noready", {31'b0, input_ready}, 32'h0);
      chk("t6_notimeout", {31'b0, timed_out}, 32'h0);
      chk("t6_cc", {24'b0, capture_count}, 32'h0);
`endif
      is_input = 1'b0;
      step();
      chk("t6_end_ready", {31'b0, input_ready}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/input_handshake_unit.md
Name: input_handshake_unit

Overview:
- Upstream of the processor core's input path: turns a processor input request plus the debounced confirmation button into a one-shot, handshaken capture of the switch bank.
- Output word feeds the core's IData input. The ready flag lets control hold enable low while the user has not confirmed.
- Guarantees one capture per request and one request per button press. A button already held when the request arrives is ignored until it is released.

Parameters:
- DATA_WIDTH, 32, width of captured word driven to the core.
- IO_WIDTH, 16, switch data bits; sw carries IO_WIDTH+1 bits, MSB is the extension-mode bit.
- WAIT_COUNT_WIDTH, 16, width of the saturating wait-cycle counter.
- CAPTURE_COUNT_WIDTH, 8, width of the wrapping capture counter.
- TIMEOUT_CYCLES, 50000, cycles in WAIT_PRESS before forced capture (only with the optional feature).

Ports:
- slow_clock  input  1  processor clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; one clock; highest priority.
- is_input  input  1  processor requests an input word; level, held until ready observed.
- confirmation  input  1  debounced confirmation button level.
- sw  input  IO_WIDTH+1  switch bank; sw[IO_WIDTH]=1 selects sign extension, 0 selects zero extension.
- IData  output  DATA_WIDTH  captured word.
- input_ready  output  1  captured word valid for current request.
- waiting  output  1  unit waiting for user press (LED drive).
- wait_cycles  output  WAIT_COUNT_WIDTH  cycles spent waiting in current request.
- capture_count  output  CAPTURE_COUNT_WIDTH  total captures since reset.
- timed_out  output  1  last capture was forced by timeout (constant 0 without the feature).

Behaviour:
- All outputs are registered. Reset values: IData=0, input_ready=0, waiting=0, wait_cycles=0, capture_count=0, timed_out=0, state=IDLE.
- IDLE:
  - is_input=1 and confirmation=1 goes to ARM.
  - is_input=1 and confirmation=0 goes to WAIT_PRESS.
  - On entry from IDLE, wait_cycles clears to 0 and timed_out clears.
- ARM (button held from earlier):
  - confirmation=0 goes to WAIT_PRESS.
  - is_input=0 goes to IDLE with no capture.
- WAIT_PRESS:
  - confirmation=1 captures sw on this edge and goes to DONE.
  - is_input=0 goes to IDLE with no capture. This takes priority over a simultaneous press.
- Capture rules:
  - IData = sign-extension of sw[IO_WIDTH-1:0] from bit IO_WIDTH-1 if sw[IO_WIDTH]=1, else zero-extension.
  - capture_count increments by 1 and wraps from all-ones to 0.
  - input_ready rises the cycle after the capturing edge, so latency from press to ready is 1 cycle.
- DONE:
  - input_ready=1 and IData is held.
  - While is_input stays 1, the unit remains in DONE and switch or button changes are ignored.
  - is_input=0 goes to IDLE; input_ready=0 from the next cycle. IData keeps its last value until the next capture.
- waiting=1 exactly in ARM and WAIT_PRESS.
- wait_cycles increments each cycle in ARM or WAIT_PRESS, saturates at all-ones, and holds in DONE and IDLE.
- Back-to-back requests: is_input dropping and re-rising goes through IDLE (minimum 1 cycle). If the button is still held, the request goes to ARM, so each press gives exactly one capture.
- Reset mid-request, in any state: next cycle is IDLE with all outputs at reset values. A press coincident with reset is discarded.

Optional Feature:
- Macro: INPUT_TIMEOUT_EN.
- Defined:
  - In WAIT_PRESS, once wait_cycles reaches TIMEOUT_CYCLES-1 with no press, the unit captures sw on that edge, goes to DONE and sets timed_out=1.
  - A press on the same edge counts as a normal capture with timed_out=0.
  - ARM is not subject to the timeout.
- Not defined: no timeout logic, timed_out tied to 0, the unit waits indefinitely.

Test Plan:
- Reset, then is_input=1, confirmation=0; after 3 cycles press with sw=17'h0_1234 -> waiting=1 then 0; input_ready=1 one cycle after press; IData=32'h00001234; capture_count=1; wait_cycles=4.
- sw=17'h1_8001, press -> IData=32'hFFFF8001. sw=17'h0_8001 on the next request -> IData=32'h00008001.
- confirmation held high before is_input rises -> state ARM, no capture; release then press with sw=17'h0_00AA -> single capture, IData=32'h000000AA, capture_count +1 only.
- In DONE, toggle the button twice and change sw to 17'h0_FFFF while is_input=1 -> IData unchanged, capture_count unchanged; drop is_input -> input_ready=0 next cycle.
- Assert reset in WAIT_PRESS on the same edge as a press -> next cycle: input_ready=0, IData=0, capture_count=0, waiting=0.
- With INPUT_TIMEOUT_EN, TIMEOUT_CYCLES=8, no press, sw=17'h0_0042 -> capture after 8 waiting cycles, IData=32'h00000042, timed_out=1, input_ready=1.
